apb_cordic_slave: RTL and testbench
===================================

// Module: apb_cordic_slave
// PURPOSE
//  Parametrised APB3 slave that fronts an external CORDIC vectoring core.
//  Holds a memory-mapped register file (X, Y, CTRL, STATUS, RESULT) and drives the core's start/done handshake.
//  Extends PREADY wait-states with a bounded timeout and reports errors on PSLVERR.
//  Sits between the AHB2APB bridge and the CORDIC core.
// PARAMETERS
//  IN_W      31   width of core_x/core_y (signed fixed point)
//  OUT_W     27   width of core_angle (signed fixed point)
//  ADDR_W    32   PADDR width
//  BASE_ADDR 32'h8C00_0000  slave base; PADDR[ADDR_W-1:8] must equal BASE_ADDR[ADDR_W-1:8]
//  WAIT_MAX  64   max wait-states on a RESULT read before timeout
// PORTS
//  PCLK        in   1       clock, all logic on rising edge
//  PRESETn     in   1       asynchronous active-low reset
//  PSEL        in   1       APB select
//  PENABLE     in   1       APB access phase
//  PWRITE      in   1       1=write, 0=read
//  PADDR       in   ADDR_W  byte address
//  PWDATA      in   32      write data
//  PRDATA      out  32      read data
//  PREADY      out  1       transfer complete
//  PSLVERR     out  1       transfer error, valid when PREADY=1
//  core_start  out  1       one-cycle start pulse to core
//  core_x      out  IN_W    X operand, held stable while busy
//  core_y      out  IN_W    Y operand, held stable while busy
//  core_done   in   1       one-cycle completion pulse from core
//  core_angle  in   OUT_W   result, valid while core_done=1
//  irq         out  1       completion interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Register map, offset = PADDR[7:0]:
//   0x00 X RW[IN_W-1:0] | 0x04 Y RW | 0x08 CTRL WO: b0 start, b1 clr_done, reads 0
//   0x0C STATUS RO: b0 busy, b1 done, b2 timeout (sticky), b3 overrun (sticky)
//   0x10 RESULT RO: angle sign-extended to 32 | 0x14 IRQ_EN RW b0
//  Reset: all registers 0, engine IDLE; PRDATA=0, PSLVERR=0, core_start=0, irq=0.
//   PREADY=1 outside wait-states.
//  Writes take effect on the PCLK edge with PSEL&PENABLE&PREADY. Reads return data in the same access cycle.
//  PRDATA is 0 when no read access is in progress.
//  Unmapped offset or base mismatch (with PSEL): zero-wait PREADY=1, PSLVERR=1. Writes ignored, reads return 0.
//  Engine FSM:
//   IDLE --start write--> RUN: X/Y snapshot to core_x/core_y; core_start=1 the next cycle; busy=1, done=0.
//   RUN --core_done--> IDLE: RESULT<=core_angle, done=1, busy=0.
//   core_done seen in IDLE is ignored.
//  Start write while busy: rejected, PSLVERR=1, overrun<=1. busy is sampled before the edge, so it is rejected even in the core_done cycle.
//  X/Y writes while busy are accepted. They take effect only at the next start.
//  clr_done coincident with a done-setting core_done: done=1 (set wins).
//  Writing 1 to STATUS b2/b3 clears them; other writes to STATUS are ignored, PSLVERR=0.
//  RESULT read while busy:
//   PREADY=0; the wait counter counts access cycles.
//   First access cycle after the done edge: PREADY=1, fresh RESULT, PSLVERR=0.
//   When the counter reaches WAIT_MAX: PREADY=1, PSLVERR=1, PRDATA=0, timeout<=1. The engine keeps running.
//  RESULT read in IDLE: zero-wait, returns the last latched angle.
//  Counter clears whenever not in a waited access. PSEL dropped mid-wait: counter clears, no side effects.
//  PRESETn asserted mid-RUN: immediate return to IDLE, all state cleared; a late core_done is ignored.
// CONFIGURATION
//  APB_CORDIC_IRQ_EN defined:
//   irq is a registered level = done & IRQ_EN.b0, cleared with done.
//  APB_CORDIC_IRQ_EN undefined:
//   irq tied 0; offset 0x14 is unmapped (PSLVERR=1).
// TESTING
//  1 Reset: PRESETn low mid-RUN -> all outputs 0, PREADY=1, STATUS=0; later core_done pulse -> no change.
//  2 Write X=0x100, Y=0x100, CTRL=1 -> one core_start pulse, core_x=core_y=0x100.
//    core_done with angle=0x0192 -> STATUS=0x2, RESULT=0x00000192.
//  3 Start, then read RESULT at once, core_done after 5 cycles -> PREADY low 6 access cycles, PRDATA=new angle, PSLVERR=0.
//  4 WAIT_MAX=8, core silent -> PREADY high on 8th wait, PSLVERR=1, PRDATA=0, STATUS b2=1.
//    Write STATUS=0x4 -> b2=0.
//  5 CTRL=1 while busy -> PSLVERR=1, STATUS b3=1, no second core_start.
//    Read offset 0x40 -> PSLVERR=1, PRDATA=0.
//  6 IRQ_EN=1 with APB_CORDIC_IRQ_EN defined -> irq=1 after done; CTRL=2 -> irq=0.
//    Build without APB_CORDIC_IRQ_EN -> irq stays 0.

Source files
------------

// File: rtl/apb_cordic_slave.sv
// apb_cordic_slave: APB3 register front-end for an external CORDIC vectoring core.
// Holds the X/Y operands, control/status and the latched result angle. Runs the
// core start/done handshake. Stretches RESULT reads with bounded wait-states.
// Optional feature macro: APB_CORDIC_IRQ_EN adds the IRQ_EN register at 0x14
// and a level interrupt on irq. Without it, irq is tied low and 0x14 is unmapped.
module apb_cordic_slave #(
  parameter int                IN_W      = 31,
  parameter int                OUT_W     = 27,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h8C00_0000),
  parameter int                WAIT_MAX  = 64
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              core_start,
  output logic [IN_W-1:0]   core_x,
  output logic [IN_W-1:0]   core_y,
  input  logic              core_done,
  input  logic [OUT_W-1:0]  core_angle,
  output logic              irq
);

  localparam logic [7:0] OFF_X      = 8'h00;
  localparam logic [7:0] OFF_Y      = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;
  localparam logic [7:0] OFF_IRQEN  = 8'h14;
  localparam int         CNT_W      = $clog2(WAIT_MAX + 1);

`ifdef APB_CORDIC_IRQ_EN
  localparam logic IRQ_MAPPED = 1'b1;
`else
  localparam logic IRQ_MAPPED = 1'b0;
`endif

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    x_q, x_d;
  logic [IN_W-1:0]    y_q, y_d;
  logic [IN_W-1:0]    core_x_q, core_x_d;
  logic [IN_W-1:0]    core_y_q, core_y_d;
  logic               core_start_q, core_start_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [7:0]  offset;
  logic        base_hit;
  logic        mapped;
  logic        access;
  logic        valid_acc;
  logic        wr_ok;
  logic        busy;
  logic        wait_read;
  logic        timeout_hit;
  logic        start_req;
  logic        start_ok;
  logic        start_rej;
  logic        clr_req;
  logic        status_wr;
  logic        rd_en;
  logic [31:0] rd_mux;
  logic        irq_en_val;
  logic        unused_bits;

  // Address decode, wait-state control, error flagging and read data mux.
  always_comb begin
    offset    = PADDR[7:0];
    base_hit  = (PADDR[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
    case (offset)
      OFF_X, OFF_Y, OFF_CTRL, OFF_STATUS, OFF_RESULT: mapped = 1'b1;
      OFF_IRQEN:                                      mapped = IRQ_MAPPED;
      default:                                        mapped = 1'b0;
    endcase
    busy        = (state_q == ST_RUN);
    access      = PSEL & PENABLE;
    valid_acc   = access & base_hit & mapped;
    // A RESULT read while the core is running stalls until done or timeout.
    wait_read   = valid_acc & ~PWRITE & (offset == OFF_RESULT) & busy;
    timeout_hit = wait_read & (wait_cnt_q == CNT_W'(WAIT_MAX));
    PREADY      = ~wait_read | timeout_hit;
    // Writes are never stretched, so PREADY is implicitly 1 here.
    wr_ok       = valid_acc & PWRITE;
    start_req   = wr_ok & (offset == OFF_CTRL) & PWDATA[0];
    // busy is the pre-edge value, so a start in the core_done cycle is still rejected.
    start_rej   = start_req & busy;
    start_ok    = start_req & ~busy;
    clr_req     = wr_ok & (offset == OFF_CTRL) & PWDATA[1] & ~start_rej;
    status_wr   = wr_ok & (offset == OFF_STATUS);
    PSLVERR     = access & (~base_hit | ~mapped | start_rej | timeout_hit);

    rd_mux = 32'h0;
    case (offset)
      OFF_X:      rd_mux = 32'(x_q);
      OFF_Y:      rd_mux = 32'(y_q);
      OFF_STATUS: rd_mux = {28'h0, overrun_q, timeout_q, done_q, busy};
      OFF_RESULT: rd_mux = 32'(signed'(result_q));
      OFF_IRQEN:  rd_mux = {31'h0, irq_en_val};
      default:    rd_mux = 32'h0;
    endcase
    rd_en  = valid_acc & ~PWRITE & PREADY & ~timeout_hit;
    PRDATA = rd_en ? rd_mux : 32'h0;
  end

  // Register file writes, engine next-state and wait counter update.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_start_d = 1'b0;
    done_d       = done_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    result_d     = result_q;

    if (wr_ok && offset == OFF_X) x_d = PWDATA[IN_W-1:0];
    if (wr_ok && offset == OFF_Y) y_d = PWDATA[IN_W-1:0];

    if (clr_req) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d      = ST_RUN;
          core_x_d     = x_q;
          core_y_d     = y_q;
          core_start_d = 1'b1;
          done_d       = 1'b0;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          state_d  = ST_IDLE;
          result_d = core_angle;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write-one-to-clear for the sticky bits; a fresh event on the same edge wins.
    if (status_wr && PWDATA[2]) timeout_d = 1'b0;
    if (status_wr && PWDATA[3]) overrun_d = 1'b0;
    if (timeout_hit) timeout_d = 1'b1;
    if (start_rej)   overrun_d = 1'b1;

    wait_cnt_d = (wait_read && !PREADY) ? (wait_cnt_q + CNT_W'(1)) : '0;
  end

  // State and register storage, cleared asynchronously by PRESETn.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      result_q     <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      result_q     <= result_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

`ifdef APB_CORDIC_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // IRQ_EN register and the interrupt level, which follows done & IRQ_EN.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ok && offset == OFF_IRQEN) irq_en_d = PWDATA[0];
    irq_d = done_d & irq_en_d;
  end

  // Interrupt enable and interrupt level storage.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_val = irq_en_q;
  assign irq        = irq_q;
`else
  assign irq_en_val = 1'b0;
  assign irq        = 1'b0;
`endif

  assign core_start  = core_start_q;
  assign core_x      = core_x_q;
  assign core_y      = core_y_q;
  // Upper write-data bits have no destination in this register map.
  assign unused_bits = ^PWDATA;

endmodule

// File: tb/tb_apb_cordic_slave.sv
// Directed bench for apb_cordic_slave with WAIT_MAX reduced to 8.
module tb_apb_cordic_slave;

  localparam int          IN_W     = 31;
  localparam int          OUT_W    = 27;
  localparam int          ADDR_W   = 32;
  localparam int          WAIT_MAX = 8;
  localparam logic [31:0] BASE     = 32'h8C00_0000;
  localparam int          LIMIT    = 100;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [ADDR_W-1:0] PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              core_start;
  logic [IN_W-1:0]   core_x;
  logic [IN_W-1:0]   core_y;
  logic              core_done = 1'b0;
  logic [OUT_W-1:0]  core_angle = '0;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;
  int n_starts = 0;

  apb_cordic_slave #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .core_start(core_start),
    .core_x(core_x), .core_y(core_y), .core_done(core_done),
    .core_angle(core_angle), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) if (core_start) n_starts++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wdata,
                          input string tag, output logic [31:0] rdata, output logic err,
                          output int waits);
    apb_xfer_addr(wr, BASE | 32'(off), wdata, tag, rdata, err, waits);
  endtask

  task automatic apb_xfer_addr(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input string tag, output logic [31:0] rdata, output logic err,
                               output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      waits++;
      if (waits > LIMIT) begin
        check_val({tag, "_pready_bound"}, 32'(PREADY), 32'h1);
        break;
      end
    end
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic pulse_done(input logic [OUT_W-1:0] angle);
    @(posedge PCLK); #1;
    core_done = 1'b1; core_angle = angle;
    @(posedge PCLK); #1;
    core_done = 1'b0;
  endtask

  task automatic done_after(input int edges, input logic [OUT_W-1:0] angle);
    repeat (edges) @(posedge PCLK);
    #1 core_done = 1'b1; core_angle = angle;
    @(posedge PCLK); #1;
    core_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    int          s0;

    // Power-on reset values
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_val("rst_prdata", PRDATA, 32'h0);
    check_val("rst_pready", 32'(PREADY), 32'h1);
    check_val("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_val("rst_start", 32'(core_start), 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);
    PRESETn = 1'b1;

    // Basic operation: operands, start pulse, completion
    apb_xfer(1'b1, 8'h00, 32'h100, "wr_x", rd, er, w);
    apb_xfer(1'b1, 8'h04, 32'h100, "wr_y", rd, er, w);
    apb_xfer(1'b0, 8'h00, 32'h0, "rd_x", rd, er, w);
    check_val("rd_x", rd, 32'h100);
    s0 = n_starts;
    apb_xfer(1'b1, 8'h08, 32'h1, "start1", rd, er, w);
    check_val("start1_err", 32'(er), 32'h0);
    repeat (3) @(negedge PCLK);
    check_val("start1_pulses", 32'(n_starts - s0), 32'h1);
    check_val("core_x", 32'(core_x), 32'h100);
    check_val("core_y", 32'(core_y), 32'h100);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_busy", rd, er, w);
    check_val("stat_busy", rd, 32'h1);
    pulse_done(27'h192);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_done", rd, er, w);
    check_val("stat_done", rd, 32'h2);
    apb_xfer(1'b0, 8'h10, 32'h0, "result1", rd, er, w);
    check_val("result1", rd, 32'h0000_0192);
    check_val("result1_waits", 32'(w), 32'h0);

    // X register holds only IN_W bits
    apb_xfer(1'b1, 8'h00, 32'hFFFF_FFFF, "wr_x_max", rd, er, w);
    apb_xfer(1'b0, 8'h00, 32'h0, "rd_x_max", rd, er, w);
    check_val("rd_x_max", rd, 32'h7FFF_FFFF);

    // Waited RESULT read completing with a negative angle
    apb_xfer(1'b1, 8'h08, 32'h1, "start2", rd, er, w);
    fork
      apb_xfer(1'b0, 8'h10, 32'h0, "wait_rd", rd, er, w);
      done_after(7, 27'h7FF_FFFB);
    join
    check_val("wait_rd_waits", 32'(w), 32'h6);
    check_val("wait_rd_data", rd, 32'hFFFF_FFFB);
    check_val("wait_rd_err", 32'(er), 32'h0);

    // Timeout on a silent core
    apb_xfer(1'b1, 8'h08, 32'h1, "start3", rd, er, w);
    apb_xfer(1'b0, 8'h10, 32'h0, "tmo_rd", rd, er, w);
    check_val("tmo_waits", 32'(w), 32'h8);
    check_val("tmo_err", 32'(er), 32'h1);
    check_val("tmo_data", rd, 32'h0);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_tmo", rd, er, w);
    check_val("stat_tmo", rd, 32'h5);
    apb_xfer(1'b1, 8'h0C, 32'h4, "clr_tmo", rd, er, w);
    check_val("clr_tmo_err", 32'(er), 32'h0);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_tmo_clr", rd, er, w);
    check_val("stat_tmo_clr", rd, 32'h1);

    // Overrun and decode errors while busy
    s0 = n_starts;
    apb_xfer(1'b1, 8'h08, 32'h1, "ovr_start", rd, er, w);
    check_val("ovr_err", 32'(er), 32'h1);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_ovr", rd, er, w);
    check_val("stat_ovr", rd, 32'h9);
    repeat (2) @(negedge PCLK);
    check_val("ovr_pulses", 32'(n_starts - s0), 32'h0);
    apb_xfer(1'b0, 8'h40, 32'h0, "unmap_rd", rd, er, w);
    check_val("unmap_err", 32'(er), 32'h1);
    check_val("unmap_data", rd, 32'h0);
    apb_xfer_addr(1'b0, 32'h8D00_0010, 32'h0, "base_rd", rd, er, w);
    check_val("base_err", 32'(er), 32'h1);
    check_val("base_data", rd, 32'h0);
    apb_xfer_addr(1'b1, 32'h8D00_0000, 32'h55, "base_wr", rd, er, w);
    check_val("base_wr_err", 32'(er), 32'h1);
    pulse_done(27'h55);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_ovr_done", rd, er, w);
    check_val("stat_ovr_done", rd, 32'hA);
    apb_xfer(1'b1, 8'h0C, 32'h8, "clr_ovr", rd, er, w);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_ovr_clr", rd, er, w);
    check_val("stat_ovr_clr", rd, 32'h2);
    apb_xfer(1'b0, 8'h10, 32'h0, "result3", rd, er, w);
    check_val("result3", rd, 32'h55);
    apb_xfer(1'b0, 8'h00, 32'h0, "rd_x_keep", rd, er, w);
    check_val("rd_x_keep", rd, 32'h7FFF_FFFF);

    // Start write landing on the core_done edge is still rejected
    apb_xfer(1'b1, 8'h08, 32'h1, "start4", rd, er, w);
    repeat (2) @(negedge PCLK);
    s0 = n_starts;
    fork
      apb_xfer(1'b1, 8'h08, 32'h1, "edge_start", rd, er, w);
      done_after(2, 27'h33);
    join
    check_val("edge_start_err", 32'(er), 32'h1);
    repeat (3) @(negedge PCLK);
    check_val("edge_start_pulses", 32'(n_starts - s0), 32'h0);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_edge", rd, er, w);
    check_val("stat_edge", rd, 32'hA);
    apb_xfer(1'b1, 8'h0C, 32'h8, "clr_ovr2", rd, er, w);
    apb_xfer(1'b0, 8'h10, 32'h0, "result4", rd, er, w);
    check_val("result4", rd, 32'h33);

    // clr_done on the same edge as core_done: done stays set
    apb_xfer(1'b1, 8'h08, 32'h1, "start5", rd, er, w);
    fork
      apb_xfer(1'b1, 8'h08, 32'h2, "edge_clr", rd, er, w);
      done_after(2, 27'h44);
    join
    check_val("edge_clr_err", 32'(er), 32'h0);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_edge_clr", rd, er, w);
    check_val("stat_edge_clr", rd, 32'h2);
    apb_xfer(1'b0, 8'h08, 32'h0, "ctrl_rd", rd, er, w);
    check_val("ctrl_rd", rd, 32'h0);

    // Interrupt
    apb_xfer(1'b1, 8'h08, 32'h2, "clr_done", rd, er, w);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_clr_done", rd, er, w);
    check_val("stat_clr_done", rd, 32'h0);
`ifdef APB_CORDIC_IRQ_EN
    apb_xfer(1'b1, 8'h14, 32'h1, "irqen_wr", rd, er, w);
    check_val("irqen_wr_err", 32'(er), 32'h0);
    apb_xfer(1'b0, 8'h14, 32'h0, "irqen_rd", rd, er, w);
    check_val("irqen_rd", rd, 32'h1);
    check_val("irq_idle", 32'(irq), 32'h0);
    apb_xfer(1'b1, 8'h08, 32'h1, "start6", rd, er, w);
    pulse_done(27'h11);
    @(negedge PCLK);
    check_val("irq_set", 32'(irq), 32'h1);
    apb_xfer(1'b1, 8'h08, 32'h2, "irq_clr", rd, er, w);
    @(negedge PCLK);
    check_val("irq_clr", 32'(irq), 32'h0);
`else
    apb_xfer(1'b1, 8'h14, 32'h1, "irqen_wr", rd, er, w);
    check_val("irqen_wr_err", 32'(er), 32'h1);
    apb_xfer(1'b0, 8'h14, 32'h0, "irqen_rd", rd, er, w);
    check_val("irqen_rd_err", 32'(er), 32'h1);
    check_val("irqen_rd", rd, 32'h0);
    apb_xfer(1'b1, 8'h08, 32'h1, "start6", rd, er, w);
    pulse_done(27'h11);
    @(negedge PCLK);
    check_val("irq_off", 32'(irq), 32'h0);
`endif

    // Reset in the middle of a run
    apb_xfer(1'b1, 8'h08, 32'h1, "start7", rd, er, w);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_val("mid_rst_prdata", PRDATA, 32'h0);
    check_val("mid_rst_pready", 32'(PREADY), 32'h1);
    check_val("mid_rst_pslverr", 32'(PSLVERR), 32'h0);
    check_val("mid_rst_start", 32'(core_start), 32'h0);
    check_val("mid_rst_core_x", 32'(core_x), 32'h0);
    check_val("mid_rst_irq", 32'(irq), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_after_rst", rd, er, w);
    check_val("stat_after_rst", rd, 32'h0);
    pulse_done(27'h77);
    apb_xfer(1'b0, 8'h0C, 32'h0, "stat_late_done", rd, er, w);
    check_val("stat_late_done", rd, 32'h0);
    apb_xfer(1'b0, 8'h10, 32'h0, "result_late_done", rd, er, w);
    check_val("result_late_done", rd, 32'h0);
    apb_xfer(1'b0, 8'h00, 32'h0, "rd_x_rst", rd, er, w);
    check_val("rd_x_rst", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
